switch_scheduler: RTL and testbench

//  Output-port scheduler for the 4-port switch. Sits after the per-input parsers:

---
 rtl/switch_scheduler.sv | 236 +++++++++++++++++++++++
 tb/tb_switch_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_scheduler.sv
// switch_scheduler: output-port scheduler for a 4-port switch.
// Each input presents a target mask and a packet length. Inputs are granted
// exclusive, atomic use of all their (non-own) target outputs for max(len,1)
// beats. Fairness is round-robin, starting from a rotating pointer.
// Optional feature macro: SCHED_STARVE_GUARD_EN. When it is defined, inputs
// that have waited STARVE_LIMIT cycles become urgent and reserve their outputs.
//
// Handshake: an input raises req_valid with stable req_target/req_len and
// holds them until grant or drop pulses for it. req_valid seen during that
// pulse cycle is ignored, so the next request is considered one cycle later.
module switch_scheduler #(
  parameter int LEN_W        = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req_valid,
  input  logic [15:0]          req_target,
  input  logic [4*LEN_W-1:0]   req_len,
  output logic [3:0]           grant,
  output logic [3:0]           drop,
  output logic [3:0]           done,
  output logic [15:0]          out_sel,
  output logic [3:0]           out_active,
  output logic [3:0]           dbg_in_state
);

  localparam int N = 4;

  typedef enum logic {
    IN_IDLE   = 1'b0,
    IN_ACTIVE = 1'b1
  } in_state_e;

  // Registered state
  in_state_e        in_state_q [N];
  in_state_e        in_state_d [N];
  logic [LEN_W-1:0] in_cnt_q   [N];
  logic [LEN_W-1:0] in_cnt_d   [N];
  logic [LEN_W-1:0] out_cnt_q  [N];
  logic [LEN_W-1:0] out_cnt_d  [N];
  logic [15:0]      out_sel_q, out_sel_d;
  logic [3:0]       out_active_q, out_active_d;
  logic [3:0]       grant_q, grant_d;
  logic [3:0]       drop_q, drop_d;
  logic [3:0]       done_q, done_d;
  logic [1:0]       ptr_q, ptr_d;

  // Decoded request view
  logic [3:0]       eff     [N];
  logic [LEN_W-1:0] len_eff [N];
  logic [3:0]       elig;
  logic [3:0]       in_busy;
  logic [3:0]       out_free;

  // Arbitration results
  logic [3:0]       win;
  logic [3:0]       claimed;
  logic [1:0]       idx;
  logic             first_found;
  logic [1:0]       first_idx;

  // Urgent-input reservation (constant zero when the guard is compiled out)
  logic             resv_any;
  logic [1:0]       resv_owner;
  logic [3:0]       resv_mask;

  // Decode each input's effective mask/length and the free/busy view of state
  always_comb begin
    elig     = '0;
    in_busy  = '0;
    out_free = '0;
    for (int i = 0; i < N; i++) begin
      eff[i]    = req_target[4*i +: 4];
      eff[i][i] = 1'b0;
      len_eff[i] = (req_len[LEN_W*i +: LEN_W] == '0) ? LEN_W'(1)
                                                     : req_len[LEN_W*i +: LEN_W];
      // The pulse cycle of a grant/drop is not a new request
      elig[i]    = req_valid[i] & ~grant_q[i] & ~drop_q[i];
      // A counter at 1 is on its last beat and may be re-granted seamlessly
      in_busy[i] = (in_state_q[i] == IN_ACTIVE) && (in_cnt_q[i] > LEN_W'(1));
      out_free[i] = (out_cnt_q[i] <= LEN_W'(1));
    end
  end

`ifdef SCHED_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  logic [WAIT_W-1:0] wait_q [N];
  logic [WAIT_W-1:0] wait_d [N];

  // Pick the lowest-index urgent input; it reserves its effective outputs
  always_comb begin
    resv_any   = 1'b0;
    resv_owner = '0;
    resv_mask  = '0;
    for (int i = 0; i < N; i++) begin
      if (!resv_any && (wait_q[i] == WAIT_W'(STARVE_LIMIT))) begin
        resv_any   = 1'b1;
        resv_owner = 2'(i);
        resv_mask  = eff[i];
      end
    end
  end

  // Wait counters count cycles spent pending, saturating at the limit
  always_comb begin
    for (int i = 0; i < N; i++) begin
      wait_d[i] = wait_q[i];
      if (win[i] || drop_d[i]) begin
        wait_d[i] = '0;
      end else if (elig[i] && (wait_q[i] < WAIT_W'(STARVE_LIMIT))) begin
        wait_d[i] = wait_q[i] + WAIT_W'(1);
      end
    end
  end

  // Wait counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) wait_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) wait_q[i] <= wait_d[i];
    end
  end
`else
  // Pure round-robin: nothing is ever reserved
  always_comb begin
    resv_any   = 1'b0;
    resv_owner = '0;
    resv_mask  = '0;
  end
`endif

  // Round-robin scan from ptr; winners claim all their outputs atomically
  always_comb begin
    win         = '0;
    claimed     = '0;
    idx         = '0;
    first_found = 1'b0;
    first_idx   = '0;
    drop_d      = '0;
    for (int i = 0; i < N; i++) begin
      drop_d[i] = elig[i] && (eff[i] == 4'b0);
    end
    for (int k = 0; k < N; k++) begin
      idx = ptr_q + 2'(k);
      if (elig[idx] && (eff[idx] != 4'b0) && !in_busy[idx] &&
          ((eff[idx] & ~out_free) == 4'b0) &&
          ((eff[idx] & claimed) == 4'b0) &&
          (((eff[idx] & resv_mask) == 4'b0) || (resv_any && (resv_owner == idx)))) begin
        win[idx] = 1'b1;
        claimed  = claimed | eff[idx];
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = idx;
        end
      end
    end
    ptr_d = first_found ? (first_idx + 2'd1) : ptr_q;
  end

  // Next-state for beat counters, output selects and per-input FSM
  always_comb begin
    for (int j = 0; j < N; j++) begin
      out_cnt_d[j]           = (out_cnt_q[j] != '0) ? (out_cnt_q[j] - LEN_W'(1)) : '0;
      out_sel_d[4*j +: 4]    = out_sel_q[4*j +: 4];
    end
    for (int i = 0; i < N; i++) begin
      if (win[i]) begin
        for (int j = 0; j < N; j++) begin
          if (eff[i][j]) begin
            out_cnt_d[j]        = len_eff[i];
            out_sel_d[4*j +: 4] = 4'b0;
            out_sel_d[4*j + i]  = 1'b1;
          end
        end
      end
    end
    for (int j = 0; j < N; j++) begin
      if (out_cnt_d[j] == '0) out_sel_d[4*j +: 4] = 4'b0;
      out_active_d[j] = (out_cnt_d[j] != '0);
    end
    for (int i = 0; i < N; i++) begin
      if (win[i]) begin
        in_cnt_d[i] = len_eff[i];
      end else begin
        in_cnt_d[i] = (in_cnt_q[i] != '0) ? (in_cnt_q[i] - LEN_W'(1)) : '0;
      end
      in_state_d[i] = (in_cnt_d[i] != '0) ? IN_ACTIVE : IN_IDLE;
      done_d[i]     = (in_cnt_d[i] == LEN_W'(1));
    end
    grant_d = win;
  end

  // All scheduler state, including the per-input IDLE/ACTIVE FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        in_state_q[i] <= IN_IDLE;
        in_cnt_q[i]   <= '0;
        out_cnt_q[i]  <= '0;
      end
      out_sel_q    <= '0;
      out_active_q <= '0;
      grant_q      <= '0;
      drop_q       <= '0;
      done_q       <= '0;
      ptr_q        <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        in_state_q[i] <= in_state_d[i];
        in_cnt_q[i]   <= in_cnt_d[i];
        out_cnt_q[i]  <= out_cnt_d[i];
      end
      out_sel_q    <= out_sel_d;
      out_active_q <= out_active_d;
      grant_q      <= grant_d;
      drop_q       <= drop_d;
      done_q       <= done_d;
      ptr_q        <= ptr_d;
    end
  end

  // Debug view of the per-input FSM
  always_comb begin
    for (int i = 0; i < N; i++) dbg_in_state[i] = in_state_q[i];
  end

  assign grant      = grant_q;
  assign drop       = drop_q;
  assign done       = done_q;
  assign out_sel    = out_sel_q;
  assign out_active = out_active_q;

endmodule

// File: tb/tb_switch_scheduler.sv
// Bench for switch_scheduler: directed scenarios plus random traffic, checked
// cycle by cycle against an interval-based reference model through a queue.
module tb_switch_scheduler;
  localparam int LEN_W        = 8;
  localparam int STARVE_LIMIT = 16;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               rst_n;
  logic [3:0]         req_valid;
  logic [15:0]        req_target;
  logic [4*LEN_W-1:0] req_len;
  logic [3:0]         grant, drop, done, out_active, dbg_in_state;
  logic [15:0]        out_sel;

  always #5 clk = ~clk;

  switch_scheduler #(.LEN_W(LEN_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_target(req_target), .req_len(req_len),
    .grant(grant), .drop(drop), .done(done),
    .out_sel(out_sel), .out_active(out_active), .dbg_in_state(dbg_in_state)
  );

  // ---------------- driver state ----------------
  logic [3:0] rv;
  logic [3:0] tg [4];
  int         ln [4];
  bit         rand_mode;

  // ---------------- reference model state ----------------
  // Each output/input remembers the cycle interval of its current packet.
  int         cyc;
  int         out_start [4];
  int         out_end   [4];
  int         out_src   [4];
  int         in_end    [4];
  int         ptr;
  int         wcnt      [4];
  logic [3:0] pg, pd;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] act_v, exp_v;
  int          n_checks, n_pass;
  bit          mon_en;

  task automatic apply();
    req_valid = rv;
    for (int i = 0; i < 4; i++) begin
      req_target[4*i +: 4]         = tg[i];
      req_len[LEN_W*i +: LEN_W]    = ln[i][LEN_W-1:0];
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    ptr = 0;
    pg  = '0;
    pd  = '0;
    for (int i = 0; i < 4; i++) begin
      out_start[i] = 0;
      out_end[i]   = -1;
      out_src[i]   = 0;
      in_end[i]    = -1;
      wcnt[i]      = 0;
    end
  endtask

  // Decide this cycle's arbitration from the rules and push next cycle's outputs
  task automatic model_step();
    logic [3:0]  eff [4];
    logic [3:0]  elig, win, drp, freem, claimed, resv, dn, act;
    logic [15:0] sel;
    int          urg, first, c, t, i, l;
    c = cyc;
    freem = '0;
    for (int j = 0; j < 4; j++) if (out_end[j] <= c) freem[j] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      eff[n]    = tg[n];
      eff[n][n] = 1'b0;
      elig[n]   = rv[n] && !pg[n] && !pd[n];
      drp[n]    = elig[n] && (eff[n] == 4'b0);
    end
    urg  = -1;
    resv = '0;
`ifdef SCHED_STARVE_GUARD_EN
    for (int n = 0; n < 4; n++) if (urg < 0 && wcnt[n] == STARVE_LIMIT) urg = n;
    if (urg >= 0) resv = eff[urg];
`endif
    win = '0;
    claimed = '0;
    first = -1;
    for (int k = 0; k < 4; k++) begin
      i = (ptr + k) % 4;
      if (elig[i] && eff[i] != 4'b0 && in_end[i] <= c &&
          (eff[i] & ~freem) == 4'b0 && (eff[i] & claimed) == 4'b0 &&
          (i == urg || (eff[i] & resv) == 4'b0)) begin
        win[i]  = 1'b1;
        claimed = claimed | eff[i];
        if (first < 0) first = i;
        l = (ln[i] == 0) ? 1 : ln[i];
        in_end[i] = c + l;
        for (int j = 0; j < 4; j++) begin
          if (eff[i][j]) begin
            out_start[j] = c + 1;
            out_end[j]   = c + l;
            out_src[j]   = i;
          end
        end
      end
    end
`ifdef SCHED_STARVE_GUARD_EN
    for (int n = 0; n < 4; n++) begin
      if (win[n] || drp[n]) wcnt[n] = 0;
      else if (elig[n] && wcnt[n] < STARVE_LIMIT) wcnt[n] = wcnt[n] + 1;
    end
`endif
    if (first >= 0) ptr = (first + 1) % 4;
    t   = c + 1;
    dn  = '0;
    act = '0;
    sel = '0;
    for (int n = 0; n < 4; n++) if (in_end[n] == t) dn[n] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (out_start[j] <= t && t <= out_end[j]) begin
        act[j] = 1'b1;
        sel[4*j + out_src[j]] = 1'b1;
      end
    end
    exp_q.push_back({win, drp, dn, sel, act});
    pg  = win;
    pd  = drp;
    cyc = t;
  endtask

  // Release requests whose grant/drop is pulsing; optionally raise new ones
  task automatic drive_cycle();
    for (int i = 0; i < 4; i++) begin
      if (pg[i] || pd[i]) rv[i] = 1'b0;
      if (rand_mode && !rv[i] && $urandom_range(0, 2) == 0) begin
        rv[i] = 1'b1;
        tg[i] = 4'($urandom_range(0, 15));
        ln[i] = int'($urandom_range(0, 4));
      end
    end
  endtask

  task automatic body();
    drive_cycle();
    apply();
    model_step();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      next_cycle();
      body();
    end
  endtask

  task automatic issue(input int i, input logic [3:0] t, input int l);
    rv[i] = 1'b1;
    tg[i] = t;
    ln[i] = l;
  endtask

  task automatic check_vec(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) $display("FAIL %s: got %h required %h", name, got, want);
    else n_pass++;
  endtask

  // Called just after a rising edge; outputs must clear at once, without an edge
  task automatic do_reset(input int hold);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    rv     = '0;
    apply();
    #1;
    check_vec("reset_outputs", {grant, drop, done, out_sel, out_active}, 32'h0);
    check_vec("reset_fsm", {28'h0, dbg_in_state}, 32'h0);
    exp_q.delete();
    model_reset();
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(32'h0);
    mon_en = 1'b1;
    body();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      act_v = {grant, drop, done, out_sel, out_active};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL cycle_outputs t=%0t: got %h required <empty queue>", $time, act_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v !== exp_v)
          $display("FAIL cycle_outputs t=%0t: got g=%b d=%b dn=%b sel=%h act=%b required g=%b d=%b dn=%b sel=%h act=%b",
                   $time, act_v[31:28], act_v[27:24], act_v[23:20], act_v[19:4], act_v[3:0],
                   exp_v[31:28], exp_v[27:24], exp_v[23:20], exp_v[19:4], exp_v[3:0]);
        else
          n_pass++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks  = 0;
    n_pass    = 0;
    mon_en    = 1'b0;
    rand_mode = 1'b0;
    rv        = '0;
    for (int i = 0; i < 4; i++) begin
      tg[i] = '0;
      ln[i] = 0;
    end
    rst_n = 1'b0;
    apply();
    model_reset();
    next_cycle();
    do_reset(2);

    // Unicast: in0 -> output 1, 3 beats
    next_cycle(); issue(0, 4'b0010, 3); body(); run(6);
    // Broadcast from in2 reaches outputs 0,1,3
    next_cycle(); issue(2, 4'b1111, 2); body(); run(5);
    // Conflict on output 3 with ptr at 0 after a fresh reset
    next_cycle(); do_reset(1);
    next_cycle(); issue(0, 4'b1000, 2); issue(1, 4'b1000, 2); body(); run(8);
    // Parallel non-overlapping grants
    next_cycle(); issue(0, 4'b0010, 2); issue(3, 4'b0100, 2); body(); run(5);
    // Own-port-only request is dropped; len 0 is a 1-beat transfer
    next_cycle(); issue(1, 4'b0010, 1); issue(2, 4'b0001, 0); body(); run(4);
    // Reset in the middle of a 5-beat multicast
    next_cycle(); issue(0, 4'b0110, 5); body(); run(3);
    next_cycle(); do_reset(2);
    run(3);

    // Random traffic, with one reset in the middle
    rand_mode = 1'b1;
    run(1500);
    next_cycle(); do_reset(1);
    run(1500);
    rand_mode = 1'b0;
    run(40);

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
